// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I forwarding / hazard scoreboard slice.
package hazard_pkg;
    localparam int HZ_REG_AW = 5;
    localparam int HZ_FSEL_W = 2;

    typedef logic [HZ_REG_AW-1:0] reg_addr_t;
    typedef logic [HZ_FSEL_W-1:0] fsel_t;

    localparam reg_addr_t REG_ZERO     = 5'd0;
    localparam fsel_t     FSEL_REGFILE = 2'd0;
endpackage

// File: rtl/fwd_port_sel.sv
// Priority forwarding-source select for one EX read port: youngest writing stage wins.
module fwd_port_sel
    import hazard_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_AW         = 5,
    parameter int FSEL_W         = 2
) (
    input  logic [REG_AW-1:0]                rs,
    input  logic [NUM_FWD_STAGES-1:0]        stg_reg_write,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_rd,
    output logic [FSEL_W-1:0]                sel
);

    // Scan oldest to youngest so the lowest matching stage index is left in sel.
    always_comb begin
        sel = FSEL_W'(FSEL_REGFILE);
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            sel = (stg_reg_write[k]
                   && (stg_rd[k*REG_AW +: REG_AW] != REG_AW'(REG_ZERO))
                   && (stg_rd[k*REG_AW +: REG_AW] == rs)) ? FSEL_W'(k + 1) : sel;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_chk.sv
// Protocol checker: a multi-cycle issue must never target a register that is still busy.
module hazard_scoreboard_chk
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 mc_issue,
    input logic [REG_AW-1:0]    mc_rd,
    input logic [2**REG_AW-1:0] sb_busy
);

    property p_issue_not_busy;
        @(posedge clk) disable iff (!rst_n)
            (mc_issue && (mc_rd != REG_AW'(REG_ZERO))) |-> !sb_busy[mc_rd];
    endproperty

    a_issue_not_busy: assert property (p_issue_not_busy);

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding, load-use and multi-cycle scoreboard hazard unit beside ID/EX.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NUM_RD_PORTS   = 2,
    parameter  int NUM_FWD_STAGES = 2,
    parameter  int REG_AW         = 5,
    parameter  int LAT_W          = 5,
    localparam int FSEL_W         = $clog2(NUM_FWD_STAGES + 1),
    localparam int NUM_REGS       = 2**REG_AW
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD_PORTS*REG_AW-1:0]   id_rs,
    input  logic [NUM_RD_PORTS-1:0]          id_rs_used,
    input  logic [REG_AW-1:0]                id_rd,
    input  logic                             id_reg_write,
    input  logic [NUM_RD_PORTS*REG_AW-1:0]   ex_rs,
    input  logic [REG_AW-1:0]                ex_rd,
    input  logic                             ex_is_load,
    input  logic [NUM_FWD_STAGES-1:0]        stg_reg_write,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_rd,
    input  logic                             mc_issue,
    input  logic [REG_AW-1:0]                mc_rd,
    input  logic [LAT_W-1:0]                 mc_lat,
    input  logic                             mc_done,
    input  logic [REG_AW-1:0]                mc_done_rd,
    output logic [NUM_RD_PORTS*FSEL_W-1:0]   fwd_sel,
    output logic                             stall,
    output logic [NUM_REGS-1:0]              sb_busy,
    output logic [31:0]                      perf_stalls,
    output logic [31:0]                      perf_fwds
);

    logic [LAT_W-1:0]               cnt_r [NUM_REGS];
    logic [NUM_REGS-1:0]            var_r;
    logic [NUM_REGS-1:0]            busy_s;
    logic [NUM_RD_PORTS*FSEL_W-1:0] fwd_raw_s;
    logic                           stall_s;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        fwd_port_sel #(
            .NUM_FWD_STAGES (NUM_FWD_STAGES),
            .REG_AW         (REG_AW),
            .FSEL_W         (FSEL_W)
        ) u_sel (
            .rs            (ex_rs[p*REG_AW +: REG_AW]),
            .stg_reg_write (stg_reg_write),
            .stg_rd        (stg_rd),
            .sel           (fwd_raw_s[p*FSEL_W +: FSEL_W])
        );
    end

    // Per-register busy: a fixed-latency countdown or an open variable-latency op.
    always_comb begin
        busy_s = {NUM_REGS{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_s[r] = (cnt_r[r] != LAT_W'(0)) || var_r[r];
        end
    end

    // Scoreboard update; an issue overrides a same-cycle done to the same register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= LAT_W'(0);
            end
            var_r <= {NUM_REGS{1'b0}};
        end else begin
            cnt_r[0] <= LAT_W'(0);
            var_r[0] <= 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (mc_issue && (mc_rd == REG_AW'(r))) begin
                    cnt_r[r] <= mc_lat;
                    var_r[r] <= (mc_lat == LAT_W'(0));
                end else begin
                    cnt_r[r] <= (cnt_r[r] != LAT_W'(0)) ? cnt_r[r] - LAT_W'(1) : cnt_r[r];
                    var_r[r] <= var_r[r] && !(mc_done && (mc_done_rd == REG_AW'(r)));
                end
            end
        end
    end

    // Stall sources: load-use, RAW on busy or just-issued reg, WAW on busy destination.
    always_comb begin
        stall_s = 1'b0;
        if (rst_n) begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (id_rs_used[p] && (id_rs[p*REG_AW +: REG_AW] != REG_AW'(REG_ZERO))) begin
                    stall_s = stall_s
                              || (ex_is_load && (id_rs[p*REG_AW +: REG_AW] == ex_rd))
                              || busy_s[id_rs[p*REG_AW +: REG_AW]]
                              || (mc_issue && (id_rs[p*REG_AW +: REG_AW] == mc_rd));
                end else begin
                    stall_s = stall_s;
                end
            end
            if (id_reg_write && (id_rd != REG_AW'(REG_ZERO)) && busy_s[id_rd]) begin
                stall_s = 1'b1;
            end else begin
                stall_s = stall_s;
            end
        end else begin
            stall_s = 1'b0;
        end
    end

    assign fwd_sel = rst_n ? fwd_raw_s : {(NUM_RD_PORTS*FSEL_W){1'b0}};
    assign stall   = stall_s;
    assign sb_busy = busy_s;

`ifdef HAZARD_PERF_EN
    localparam int PCNT_W = $clog2(NUM_RD_PORTS + 1);

    logic [31:0]       perf_stalls_r;
    logic [31:0]       perf_fwds_r;
    logic [PCNT_W-1:0] nfwd_s;
    logic [32:0]       fwd_sum_s;

    // Number of ports taking a forwarded operand this cycle.
    always_comb begin
        nfwd_s = PCNT_W'(0);
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            nfwd_s = nfwd_s + ((fwd_sel[p*FSEL_W +: FSEL_W] != FSEL_W'(0)) ? PCNT_W'(1) : PCNT_W'(0));
        end
        fwd_sum_s = {1'b0, perf_fwds_r} + 33'(nfwd_s);
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stalls_r <= 32'd0;
            perf_fwds_r   <= 32'd0;
        end else begin
            if (stall_s && (perf_stalls_r != 32'hFFFF_FFFF)) begin
                perf_stalls_r <= perf_stalls_r + 32'd1;
            end else begin
                perf_stalls_r <= perf_stalls_r;
            end
            perf_fwds_r <= fwd_sum_s[32] ? 32'hFFFF_FFFF : fwd_sum_s[31:0];
        end
    end

    assign perf_stalls = perf_stalls_r;
    assign perf_fwds   = perf_fwds_r;
`else
    assign perf_stalls = 32'd0;
    assign perf_fwds   = 32'd0;
`endif

    hazard_scoreboard_chk #(
        .REG_AW (REG_AW)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .mc_issue (mc_issue),
        .mc_rd    (mc_rd),
        .sb_busy  (busy_s)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic against a cycle-number based reference model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic [9:0]  ex_rs;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic [1:0]  stg_reg_write;
    logic [9:0]  stg_rd;
    logic        mc_issue;
    logic [4:0]  mc_rd;
    logic [4:0]  mc_lat;
    logic        mc_done;
    logic [4:0]  mc_done_rd;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [31:0] sb_busy;
    logic [31:0] perf_stalls;
    logic [31:0] perf_fwds;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a register is busy until a known cycle, or until its done arrives.
    longint cyc = 0;
    longint ready_m [32];
    bit     varp_m  [32];
    longint m_stalls = 0;
    longint m_fwds = 0;

    hazard_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs         (id_rs),
        .id_rs_used    (id_rs_used),
        .id_rd         (id_rd),
        .id_reg_write  (id_reg_write),
        .ex_rs         (ex_rs),
        .ex_rd         (ex_rd),
        .ex_is_load    (ex_is_load),
        .stg_reg_write (stg_reg_write),
        .stg_rd        (stg_rd),
        .mc_issue      (mc_issue),
        .mc_rd         (mc_rd),
        .mc_lat        (mc_lat),
        .mc_done       (mc_done),
        .mc_done_rd    (mc_done_rd),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .sb_busy       (sb_busy),
        .perf_stalls   (perf_stalls),
        .perf_fwds     (perf_fwds)
    );

    always #5 clk = ~clk;

    function automatic bit model_busy(input logic [4:0] r);
        return (r != 5'd0) && (varp_m[r] || (cyc < ready_m[r]));
    endfunction

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = model_busy(5'(r));
        return v;
    endfunction

    function automatic logic [1:0] model_fwd(input int p);
        logic [4:0] rs;
        rs = ex_rs[p*5 +: 5];
        if (!rst_n || rs == 5'd0) return 2'd0;
        if (stg_reg_write[0] && stg_rd[4:0] == rs) return 2'd1;
        if (stg_reg_write[1] && stg_rd[9:5] == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit model_stall();
        bit s;
        logic [4:0] rs;
        s = 1'b0;
        if (!rst_n) return 1'b0;
        for (int p = 0; p < 2; p++) begin
            rs = id_rs[p*5 +: 5];
            if (id_rs_used[p] && rs != 5'd0) begin
                if (ex_is_load && rs == ex_rd) s = 1'b1;
                if (model_busy(rs)) s = 1'b1;
                if (mc_issue && rs == mc_rd) s = 1'b1;
            end
        end
        if (id_reg_write && model_busy(id_rd)) s = 1'b1;
        return s;
    endfunction

    task automatic idle();
        id_rs = 10'd0; id_rs_used = 2'b00; id_rd = 5'd0; id_reg_write = 1'b0;
        ex_rs = 10'd0; ex_rd = 5'd0; ex_is_load = 1'b0;
        stg_reg_write = 2'b00; stg_rd = 10'd0;
        mc_issue = 1'b0; mc_rd = 5'd0; mc_lat = 5'd0; mc_done = 1'b0; mc_done_rd = 5'd0;
    endtask

    // Advance one clock, updating the model with what the DUT sampled at the edge.
    task automatic tick();
        bit es;
        int nf;
        es = model_stall();
        nf = (model_fwd(0) != 2'd0) + (model_fwd(1) != 2'd0);
        @(posedge clk);
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin ready_m[r] = 0; varp_m[r] = 1'b0; end
            m_stalls = 0; m_fwds = 0;
        end else begin
            if (mc_done && mc_done_rd != 5'd0) varp_m[mc_done_rd] = 1'b0;
            if (mc_issue && mc_rd != 5'd0) begin
                varp_m[mc_rd] = (mc_lat == 5'd0);
                ready_m[mc_rd] = (mc_lat == 5'd0) ? 0 : cyc + 1 + longint'(mc_lat);
            end
            m_stalls += es;
            m_fwds += nf;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle();
        id_rs = {5'd3, 5'd3}; id_rs_used = 2'b11; ex_is_load = 1'b1; ex_rd = 5'd3;
        stg_reg_write = 2'b11; stg_rd = {5'd4, 5'd4}; ex_rs = {5'd4, 5'd4};
        tick(); tick();
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %0d expected 0", stall); end
        vectors++; if (fwd_sel !== 4'd0) begin miscompares++; $display("FAIL reset_fwd: got %0h expected 0", fwd_sel); end
        vectors++; if (sb_busy !== 32'd0) begin miscompares++; $display("FAIL reset_busy: got %0h expected 0", sb_busy); end
`ifdef HAZARD_PERF_EN
        vectors++; if (perf_stalls !== 32'd0 || perf_fwds !== 32'd0) begin miscompares++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_stalls, perf_fwds); end
`endif
        idle(); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        idle();
        stg_reg_write = 2'b11; stg_rd = {5'd5, 5'd5}; ex_rs = {5'd5, 5'd5};
        #1;
        vectors++; if (fwd_sel !== 4'b0101) begin miscompares++; $display("FAIL fwd_exmem: got %0h expected 5", fwd_sel); end
        stg_reg_write = 2'b10;
        #1;
        vectors++; if (fwd_sel !== 4'b1010) begin miscompares++; $display("FAIL fwd_memwb: got %0h expected a", fwd_sel); end
        stg_reg_write = 2'b11; stg_rd = 10'd0; ex_rs = 10'd0;
        #1;
        vectors++; if (fwd_sel !== 4'd0) begin miscompares++; $display("FAIL fwd_x0: got %0h expected 0", fwd_sel); end
        stg_rd = {5'd8, 5'd12}; ex_rs = {5'd12, 5'd8};
        #1;
        vectors++; if (fwd_sel !== 4'b0110) begin miscompares++; $display("FAIL fwd_mixed: got %0h expected 6", fwd_sel); end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs = {5'd7, 5'd1}; id_rs_used = 2'b10;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL load_use: got %0d expected 1", stall); end
        tick();
        ex_is_load = 1'b0;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL load_use_bubble: got %0d expected 0", stall); end
        ex_is_load = 1'b1; id_rs_used = 2'b01;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL load_use_unused: got %0d expected 0", stall); end
        ex_rd = 5'd0; id_rs = 10'd0; id_rs_used = 2'b11;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL load_use_x0: got %0d expected 0", stall); end
        idle(); tick();
    endtask

    task automatic test_fixed_latency();
        idle();
        mc_issue = 1'b1; mc_rd = 5'd9; mc_lat = 5'd3; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        for (int c = 0; c <= 4; c++) begin
            #1;
            vectors++; if (stall !== (c < 4)) begin miscompares++; $display("FAIL fixed_stall c%0d: got %0d expected %0d", c, stall, c < 4); end
            vectors++; if (sb_busy[9] !== (c >= 1 && c <= 3)) begin miscompares++; $display("FAIL fixed_busy c%0d: got %0d expected %0d", c, sb_busy[9], c >= 1 && c <= 3); end
            tick();
            mc_issue = 1'b0;
        end
        idle();
    endtask

    task automatic test_variable_latency();
        idle();
        mc_issue = 1'b1; mc_rd = 5'd4; mc_lat = 5'd0;
        tick();
        idle();
        for (int c = 0; c < 10; c++) begin
            #1;
            vectors++; if (sb_busy[4] !== 1'b1) begin miscompares++; $display("FAIL var_hold c%0d: got %0d expected 1", c, sb_busy[4]); end
            tick();
        end
        mc_done = 1'b1; mc_done_rd = 5'd4;
        tick();
        idle();
        #1;
        vectors++; if (sb_busy[4] !== 1'b0) begin miscompares++; $display("FAIL var_done: got %0d expected 0", sb_busy[4]); end
    endtask

    task automatic test_issue_done_collision();
        idle();
        mc_issue = 1'b1; mc_rd = 5'd6; mc_lat = 5'd0; mc_done = 1'b1; mc_done_rd = 5'd6;
        tick();
        idle();
        id_reg_write = 1'b1; id_rd = 5'd6;
        #1;
        vectors++; if (sb_busy[6] !== 1'b1) begin miscompares++; $display("FAIL collide_busy: got %0d expected 1", sb_busy[6]); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL collide_waw: got %0d expected 1", stall); end
        idle(); mc_done = 1'b1; mc_done_rd = 5'd6;
        tick();
        idle();
    endtask

    task automatic test_mid_reset();
        idle();
        mc_issue = 1'b1; mc_rd = 5'd3; mc_lat = 5'd0;
        tick();
        mc_rd = 5'd9; mc_lat = 5'd20;
        tick();
        idle();
        #1;
        vectors++; if (sb_busy !== 32'h0000_0208) begin miscompares++; $display("FAIL pre_reset_busy: got %0h expected 208", sb_busy); end
        rst_n = 1'b0; id_rs = {5'd3, 5'd9}; id_rs_used = 2'b11;
        stg_reg_write = 2'b11; stg_rd = {5'd2, 5'd2}; ex_rs = {5'd2, 5'd2};
        #1;
        vectors++; if (stall !== 1'b0 || fwd_sel !== 4'd0) begin miscompares++; $display("FAIL in_reset: got stall=%0d fwd=%0h expected 0/0", stall, fwd_sel); end
        tick();
        #1;
        vectors++; if (sb_busy !== 32'd0) begin miscompares++; $display("FAIL mid_reset_busy: got %0h expected 0", sb_busy); end
`ifdef HAZARD_PERF_EN
        vectors++; if (perf_stalls !== 32'd0 || perf_fwds !== 32'd0) begin miscompares++; $display("FAIL mid_reset_perf: got %0d/%0d expected 0/0", perf_stalls, perf_fwds); end
`endif
        rst_n = 1'b1; idle();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            id_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_rs_used = 2'($urandom);
            id_rd = 5'($urandom_range(0, 7)); id_reg_write = 1'($urandom);
            ex_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            ex_rd = 5'($urandom_range(0, 7)); ex_is_load = ($urandom_range(0, 3) == 0);
            stg_reg_write = 2'($urandom);
            stg_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            mc_rd = 5'($urandom_range(0, 7)); mc_lat = 5'($urandom_range(0, 6));
            mc_issue = ($urandom_range(0, 3) == 0) && !model_busy(mc_rd);
            mc_done = ($urandom_range(0, 2) == 0); mc_done_rd = 5'($urandom_range(0, 7));
            #1;
            vectors++; if (fwd_sel !== {model_fwd(1), model_fwd(0)}) begin miscompares++; $display("FAIL rnd_fwd n%0d: got %0h expected %0h", n, fwd_sel, {model_fwd(1), model_fwd(0)}); end
            vectors++; if (stall !== model_stall()) begin miscompares++; $display("FAIL rnd_stall n%0d: got %0d expected %0d", n, stall, model_stall()); end
            vectors++; if (sb_busy !== model_busy_vec()) begin miscompares++; $display("FAIL rnd_busy n%0d: got %0h expected %0h", n, sb_busy, model_busy_vec()); end
            tick();
        end
        rst_n = 1'b1; idle();
        #1;
`ifdef HAZARD_PERF_EN
        vectors++; if (perf_stalls !== 32'(m_stalls)) begin miscompares++; $display("FAIL rnd_perf_stalls: got %0d expected %0d", perf_stalls, m_stalls); end
        vectors++; if (perf_fwds !== 32'(m_fwds)) begin miscompares++; $display("FAIL rnd_perf_fwds: got %0d expected %0d", perf_fwds, m_fwds); end
`else
        vectors++; if (perf_stalls !== 32'd0 || perf_fwds !== 32'd0) begin miscompares++; $display("FAIL perf_tied: got %0d/%0d expected 0/0", perf_stalls, perf_fwds); end
`endif
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin ready_m[r] = 0; varp_m[r] = 1'b0; end
        test_reset();
        test_forwarding();
        test_load_use();
        test_fixed_latency();
        test_variable_latency();
        test_issue_done_collision();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
